uart_rx_async_core: RTL and testbench
=====================================

// Module: uart_rx_async_core
// PURPOSE
//  Asynchronous UART receiver. It oversamples the serial input at 16x baud and validates the start bit.
//  It shifts in 7/8 data bits LSB first, checks optional parity and the stop bit, then delivers the byte
//  to the APB-side holding register (RX_FIFO=0) or to the RX FIFO write port (RX_FIFO=1).
//  It is the receive counterpart of the core's transmitter and shares its baud generator and frame format.
// PARAMETERS
//  RX_FIFO   0  0=single holding register with rx_ready handshake; 1=write bytes into external RX FIFO
// PORTS
//  clk          in   1  system clock
//  aresetn      in   1  asynchronous reset, active-low
//  samp_pulse   in   1  1-clk enable at 16x baud rate (from baud generator)
//  rx           in   1  serial line, asynchronous to clk, idle high
//  bit8         in   1  1=8 data bits, 0=7 data bits
//  parity_en    in   1  1=parity bit present after data
//  odd_n_even   in   1  1=odd parity, 0=even parity
//  read_rx_byte in   1  1-clk pulse: CPU consumed rx_dout (RX_FIFO=0 only)
//  clear_err    in   1  1-clk pulse: clear parity_err, framing_err, overflow
//  fifo_full    in   1  RX FIFO full (RX_FIFO=1 only)
//  rx_dout      out  8  received byte; bit7=0 in 7-bit mode
//  rx_ready     out  1  byte available in rx_dout (RX_FIFO=0; tied 0 when RX_FIFO=1)
//  fifo_write_n out  1  active-low 1-clk FIFO write strobe (RX_FIFO=1; tied 1 when RX_FIFO=0)
//  parity_err   out  1  sticky: parity mismatch on a delivered byte
//  framing_err  out  1  sticky: stop bit sampled low
//  overflow     out  1  sticky: byte arrived with rx_ready=1 or fifo_full=1
// BEHAVIOUR
//  Reset: rx_dout=0, rx_ready=0, fifo_write_n=1, all error flags=0, state=IDLE, counters=0, rx sync flops=1.
//  rx passes through a 2-flop synchronizer. A 3-entry shift register of synced samples advances on samp_pulse.
//   The majority of its 3 entries is the voted bit.
//  Logic acts only on clocks with samp_pulse=1, except output strobes, clears and the read handshake.
//  A 4-bit sample counter runs 0..15 and wraps. A data bit is taken when the counter = 8, using the voted bit.
//  FSM:
//   IDLE   : synced rx=0 -> START, counter=0. Latch bit8, parity_en, odd_n_even for the whole frame.
//   START  : counter=8: voted=1 -> IDLE (glitch rejected, no flags); voted=0 -> DATA, bit_idx=0.
//   DATA   : counter=8: shift voted bit into [bit_idx]. After the last bit (idx 7, or idx 6 when 7-bit)
//            go to PARITY if parity_en, else STOP.
//   PARITY : counter=8: perr = voted ^ XOR(data) ^ odd_n_even -> STOP
//            (matches transmitter: parity bit = odd_n_even ^ XOR(data)).
//   STOP   : counter=8: deliver byte, framing_err|=~voted, parity_err|=perr -> IDLE.
//            Return happens at mid-stop so the next start edge is caught.
//  Delivery, RX_FIFO=0:
//   - rx_dout and rx_ready=1 are updated on the clock after the stop mid-sample.
//   - If rx_ready=1 with no read_rx_byte on that clock: overflow=1 and rx_dout is overwritten.
//   - read_rx_byte clears rx_ready next clk. If read and delivery coincide: rx_ready stays 1, no overflow.
//  Delivery, RX_FIFO=1:
//   - rx_dout is valid and fifo_write_n=0 for exactly 1 clk after the stop mid-sample.
//   - If fifo_full=1: no strobe and overflow=1.
//  If clear_err coincides with a new error, the new error wins (flag=1).
//  Error flags are independent; a byte with framing or parity error is still delivered.
//  A break (rx held low) yields a 0x00 byte with framing_err, then waits in IDLE.
//   A new frame starts on the next low seen after rx returns high.
//  Config inputs changing mid-frame have no effect until the next START.
// TESTING
//  8N1 0xA5 at 16x pulses -> rx_dout=0xA5, rx_ready=1, no errors; read_rx_byte -> rx_ready=0.
//  7E1 0x35 with parity bit=1 -> rx_dout=0x35, parity_err=1; repeat with parity bit=0 -> no new error.
//  8O1 0x00 with stop bit forced 0 -> framing_err=1, byte 0x00 delivered; clear_err -> flags 0.
//  rx low pulse of 5 samp_pulses only -> FSM returns to IDLE, no rx_ready, no flags.
//  Two bytes 0x11,0x22 back-to-back, no read -> rx_dout=0x22, overflow=1;
//   RX_FIFO=1 with fifo_full=1 -> no write strobe, overflow=1.
//  aresetn low mid-DATA -> all outputs at reset values; next frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_async_core.sv
// rtl/uart_rx_async_core.sv - 16x oversampled UART receiver with holding-register or FIFO delivery
module uart_rx_async_core #(
  parameter bit RX_FIFO = 1'b0
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       samp_pulse,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  input  logic       clear_err,
  input  logic       fifo_full,
  output logic [7:0] rx_dout,
  output logic       rx_ready,
  output logic       fifo_write_n,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state, state_nxt;
  logic        rx_s1, rx_s2;
  logic [2:0]  samp_sh;
  logic        voted;
  logic [3:0]  cnt;
  logic        mid;
  logic [2:0]  bit_idx;
  logic        last_bit;
  logic [7:0]  data;
  logic        bit8_l, pen_l, odd_l;
  logic        perr;
  logic        wait_high;
  logic        dlv, dlv_ferr;
  logic        start_frame, take_bit, take_par, take_stop;

  assign voted    = (samp_sh[0] & samp_sh[1]) | (samp_sh[0] & samp_sh[2]) | (samp_sh[1] & samp_sh[2]);
  assign mid      = samp_pulse && (cnt == 4'd8);
  assign last_bit = (bit_idx == 3'd7) || (!bit8_l && (bit_idx == 3'd6));

  // Two-flop synchronizer plus three-sample history for majority voting
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      samp_sh <= 3'b111;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      if (samp_pulse) samp_sh <= {samp_sh[1:0], rx_s2};
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic; every bit decision is made at the mid-bit sample
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (samp_pulse && !wait_high && !rx_s2) state_nxt = START;
      START:   if (mid) state_nxt = voted ? IDLE : DATA;
      DATA:    if (mid && last_bit) state_nxt = pen_l ? PARITY : STOP;
      PARITY:  if (mid) state_nxt = STOP;
      STOP:    if (mid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: per-sample datapath controls
  always_comb begin
    start_frame = (state == IDLE) && samp_pulse && !wait_high && !rx_s2;
    take_bit    = (state == DATA) && mid;
    take_par    = (state == PARITY) && mid;
    take_stop   = (state == STOP) && mid;
  end

  // Sample counter, shift register, frame config latch and parity/break tracking
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt       <= 4'd0;
      bit_idx   <= 3'd0;
      data      <= 8'd0;
      bit8_l    <= 1'b0;
      pen_l     <= 1'b0;
      odd_l     <= 1'b0;
      perr      <= 1'b0;
      wait_high <= 1'b0;
      dlv       <= 1'b0;
      dlv_ferr  <= 1'b0;
    end else begin
      dlv      <= take_stop;
      dlv_ferr <= take_stop & ~voted;
      if (samp_pulse) cnt <= start_frame ? 4'd0 : cnt + 4'd1;
      if (start_frame) begin
        bit_idx <= 3'd0;
        data    <= 8'd0;
        bit8_l  <= bit8;
        pen_l   <= parity_en;
        odd_l   <= odd_n_even;
        perr    <= 1'b0;
      end
      if (take_bit) begin
        data[bit_idx] <= voted;
        bit_idx       <= bit_idx + 3'd1;
      end
      if (take_par) perr <= voted ^ (^data) ^ odd_l;
      // A low stop bit may be a break: hold off new frames until the line goes high
      if (take_stop && !voted)                             wait_high <= 1'b1;
      else if ((state == IDLE) && samp_pulse && rx_s2)     wait_high <= 1'b0;
    end
  end

  // Byte delivery to the holding register or FIFO, with sticky error flags
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rx_dout      <= 8'd0;
      rx_ready     <= 1'b0;
      fifo_write_n <= 1'b1;
      parity_err   <= 1'b0;
      framing_err  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      fifo_write_n <= 1'b1;
      if (clear_err) begin
        parity_err  <= 1'b0;
        framing_err <= 1'b0;
        overflow    <= 1'b0;
      end
      if (dlv && perr)     parity_err  <= 1'b1;
      if (dlv && dlv_ferr) framing_err <= 1'b1;
      if (RX_FIFO) begin
        rx_ready <= 1'b0;
        if (dlv) begin
          if (fifo_full) begin
            overflow <= 1'b1;
          end else begin
            rx_dout      <= data;
            fifo_write_n <= 1'b0;
          end
        end
      end else begin
        if (dlv) begin
          rx_dout  <= data;
          rx_ready <= 1'b1;
          if (rx_ready && !read_rx_byte) overflow <= 1'b1;
        end else if (read_rx_byte) begin
          rx_ready <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_async_core.sv
// tb/tb_uart_rx_async_core.sv - scoreboard bench for uart_rx_async_core, both delivery modes
module tb_uart_rx_async_core;

  logic clk = 1'b0, aresetn = 1'b0, samp_pulse = 1'b0, rx = 1'b1;
  logic bit8 = 1'b1, parity_en = 1'b0, odd_n_even = 1'b0;
  logic read_rx_byte = 1'b0, clear_err = 1'b0, fifo_full = 1'b0;

  logic [7:0] rx_dout0, rx_dout1;
  logic rx_ready0, fwn0, perr0, ferr0, ovf0;
  logic rx_ready1, fwn1, perr1, ferr1, ovf1;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;
  int frames = 0;

  uart_rx_async_core #(.RX_FIFO(1'b0)) u_hold (
    .clk(clk), .aresetn(aresetn), .samp_pulse(samp_pulse), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .read_rx_byte(read_rx_byte), .clear_err(clear_err), .fifo_full(fifo_full),
    .rx_dout(rx_dout0), .rx_ready(rx_ready0), .fifo_write_n(fwn0),
    .parity_err(perr0), .framing_err(ferr0), .overflow(ovf0)
  );

  uart_rx_async_core #(.RX_FIFO(1'b1)) u_fifo (
    .clk(clk), .aresetn(aresetn), .samp_pulse(samp_pulse), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .read_rx_byte(read_rx_byte), .clear_err(clear_err), .fifo_full(fifo_full),
    .rx_dout(rx_dout1), .rx_ready(rx_ready1), .fifo_write_n(fwn1),
    .parity_err(perr1), .framing_err(ferr1), .overflow(ovf1)
  );

  always #5 clk = ~clk;

  // 16x baud enable: one clock high out of every four
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 samp_pulse = 1'b1;
      @(posedge clk);
      #1 samp_pulse = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (samp_pulse !== 1'b1);
    end
    #2;
  endtask

  task automatic pulse_read();
    @(posedge clk); #1 read_rx_byte = 1'b1;
    @(posedge clk); #1 read_rx_byte = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_err = 1'b1;
    @(posedge clk); #1 clear_err = 1'b0;
  endtask

  // Reference: the line carries start, data LSB first, optional parity, stop.
  // Expected byte is the data masked to the frame width; a parity error means the
  // transmitted parity bit differs from odd_n_even ^ XOR(data).
  task automatic send_frame(input logic [7:0] d, input bit b8, input bit pen, input bit odd,
                            input bit flip_par, input bit stop_bit);
    logic [7:0] dm;
    logic       pb;
    exp_t       e;
    dm = b8 ? d : (d & 8'h7f);
    pb = odd ^ (^dm) ^ flip_par;
    bit8 = b8; parity_en = pen; odd_n_even = odd;
    e.d = dm;
    e.pe = pen & flip_par;
    e.fe = ~stop_bit;
    if (!fifo_full) q.push_back(e);
    frames++;
    rx = 1'b0; wait_pulses(16);
    for (int i = 0; i < (b8 ? 8 : 7); i++) begin
      rx = dm[i]; wait_pulses(16);
    end
    if (pen) begin
      rx = pb; wait_pulses(16);
    end
    rx = stop_bit; wait_pulses(16);
    rx = 1'b1; wait_pulses(16);
  endtask

  // Monitor: every FIFO write strobe must match the oldest expected byte
  always @(negedge clk) begin
    if (aresetn && fwn1 === 1'b0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got byte %0h expected no write", rx_dout1);
      end else begin
        mon_e = q.pop_front();
        chk("fifo_byte", {24'd0, rx_dout1}, {24'd0, mon_e.d});
        chk("hold_byte", {24'd0, rx_dout0}, {24'd0, mon_e.d});
        chk("hold_ready", {31'd0, rx_ready0}, 32'd1);
        chk("parity_err", {31'd0, perr1}, {31'd0, mon_e.pe});
        chk("framing_err", {31'd0, ferr1}, {31'd0, mon_e.fe});
      end
    end
  end

  initial begin
    logic [7:0] rd;
    bit b8, pen, odd, flip, stp;
    exp_t e;

    repeat (3) @(negedge clk);
    chk("rst_dout", {24'd0, rx_dout0}, 32'd0);
    chk("rst_ready", {31'd0, rx_ready0}, 32'd0);
    chk("rst_fwn", {31'd0, fwn1}, 32'd1);
    chk("rst_flags", {29'd0, perr0, ferr0, ovf0}, 32'd0);
    @(posedge clk); #1 aresetn = 1'b1;
    wait_pulses(8);

    // 8N1 0xA5
    pulse_clear();
    send_frame(8'hA5, 1, 0, 0, 0, 1);
    chk("a5_flags", {29'd0, perr0, ferr0, ovf0}, 32'd0);
    pulse_read();
    @(negedge clk) chk("a5_read_ready", {31'd0, rx_ready0}, 32'd0);

    // 7E1 0x35 with wrong then right parity
    pulse_clear();
    send_frame(8'h35, 0, 1, 0, 1, 1);
    chk("7e1_perr_hold", {31'd0, perr0}, 32'd1);
    pulse_read();
    pulse_clear();
    send_frame(8'h35, 0, 1, 0, 0, 1);
    chk("7e1_no_perr", {31'd0, perr0}, 32'd0);
    pulse_read();

    // 8O1 0x00 with low stop bit, then clear
    pulse_clear();
    send_frame(8'h00, 1, 1, 1, 0, 0);
    chk("8o1_ferr", {31'd0, ferr0}, 32'd1);
    pulse_read();
    pulse_clear();
    @(negedge clk) chk("cleared_flags", {29'd0, perr0, ferr0, ovf0}, 32'd0);

    // Start-bit glitch of 5 samples
    rx = 1'b0; wait_pulses(5);
    rx = 1'b1; wait_pulses(48);
    chk("glitch_ready", {31'd0, rx_ready0}, 32'd0);
    chk("glitch_flags", {29'd0, perr0, ferr0, ovf0}, 32'd0);

    // Back-to-back bytes without a read
    send_frame(8'h11, 1, 0, 0, 0, 1);
    send_frame(8'h22, 1, 0, 0, 0, 1);
    chk("ovf_hold", {31'd0, ovf0}, 32'd1);
    chk("ovf_dout", {24'd0, rx_dout0}, 32'h22);
    chk("ovf_fifo_none", {31'd0, ovf1}, 32'd0);
    pulse_read();
    pulse_clear();

    // FIFO full drops the byte
    fifo_full = 1'b1;
    send_frame(8'h3C, 1, 0, 0, 0, 1);
    chk("full_ovf", {31'd0, ovf1}, 32'd1);
    chk("full_hold_no_ovf", {31'd0, ovf0}, 32'd0);
    fifo_full = 1'b0;
    pulse_read();
    pulse_clear();

    // Break: line low well past one frame gives a single 0x00 with framing error
    bit8 = 1'b1; parity_en = 1'b0;
    e.d = 8'h00; e.pe = 1'b0; e.fe = 1'b1;
    q.push_back(e);
    frames++;
    rx = 1'b0; wait_pulses(16 * 22);
    chk("break_ferr", {31'd0, ferr0}, 32'd1);
    chk("break_ready", {31'd0, rx_ready0}, 32'd1);
    rx = 1'b1; wait_pulses(32);
    pulse_read();
    pulse_clear();

    // Reset in the middle of the data bits
    send_frame(8'hC3, 1, 0, 0, 0, 1);
    rx = 1'b0; wait_pulses(16);
    rx = 1'b1; wait_pulses(16);
    rx = 1'b0; wait_pulses(8);
    @(posedge clk); #1 aresetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_dout", {24'd0, rx_dout0}, 32'd0);
    chk("mid_rst_ready", {31'd0, rx_ready0}, 32'd0);
    chk("mid_rst_fwn", {31'd0, fwn1}, 32'd1);
    chk("mid_rst_flags", {29'd0, perr0, ferr0, ovf0}, 32'd0);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 aresetn = 1'b1;
    wait_pulses(32);
    send_frame(8'h5A, 1, 0, 0, 0, 1);
    chk("post_rst_flags", {29'd0, perr0, ferr0, ovf0}, 32'd0);
    pulse_read();

    // Randomized frames in all formats
    for (int n = 0; n < 18; n++) begin
      rd   = 8'($urandom);
      b8   = 1'($urandom_range(0, 1));
      pen  = 1'($urandom_range(0, 1));
      odd  = 1'($urandom_range(0, 1));
      flip = ($urandom_range(0, 3) == 0);
      stp  = ($urandom_range(0, 5) != 0);
      pulse_clear();
      send_frame(rd, b8, pen, odd, flip, stp);
      pulse_read();
      @(negedge clk);
      chk("rand_read_ready", {31'd0, rx_ready0}, 32'd0);
      chk("rand_no_ovf", {31'd0, ovf0}, 32'd0);
    end

    wait_pulses(16);
    chk("all_delivered", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
